seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_pkg.sv | 20 ++
 rtl/seq_multiplier_ripple_add8.sv | 26 ++
 rtl/seq_multiplier.sv | 106 ++++++++++
 tb/tb_seq_multiplier.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Holds the controller state encoding, the default operand width and the step-counter width.
package seq_multiplier_pkg;

    localparam int WIDTH_DEFAULT = 8;

    // The counter must be able to hold the value WIDTH, so it needs clog2(WIDTH+1) bits.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_multiplier_ripple_add8.sv
// WIDTH-bit ripple-carry adder used for the add step of the multiplier.
// Plain full-adder chain with an explicit carry-in and carry-out.
module ripple_add8
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one partial-product step per RUN cycle, WIDTH steps per product.
// Control FSM and all datapath registers live here; only the adder is a separate module.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P,
    output state_e               state_o
);

    localparam int CNT_W = cnt_width(WIDTH);

    // Handshake: start is a request sampled only while idle (busy=0, done=0); A/B are
    // captured on the accepting edge. busy stays high for exactly WIDTH cycles, then done
    // pulses for one cycle with P valid. P then holds until the next product is written.

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    logic [WIDTH-1:0]     acc_hi;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic [WIDTH:0]       step;
    logic [2*WIDTH-1:0]   acc_shifted;

    assign acc_hi = acc_q[2*WIDTH-1:WIDTH];

    ripple_add8 #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (acc_hi),
        .b    (mcand_q),
        .cin  (1'b0),
        .s    (add_sum),
        .cout (add_cout)
    );

    // {carry, sum, acc_lo} >> 1: the carry lands in the MSB and acc[0] is consumed.
    assign step        = acc_q[0] ? {add_cout, add_sum} : {1'b0, acc_hi};
    assign acc_shifted = {step, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = A;
                    acc_d   = {{WIDTH{1'b0}}, B};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_shifted;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    p_d     = acc_shifted;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign P       = p_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table, multi-cycle corner sequences and a
// random regression, with expected products queued at drive time and popped on done.
module tb_seq_multiplier;
    import seq_multiplier_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*W-1:0] P;
    state_e         state_o;

    int checks   = 0;
    int failures = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_p;

    vec_t vecs[11];

    seq_multiplier #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .P       (P),
        .state_o (state_o)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pop one expected product when done is seen and compare with P.
    task automatic score_done();
        logic [2*W-1:0] e;
        if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'(0));
        end else begin
            e = exp_q.pop_front();
            check("product", 32'(P), 32'(e));
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    // After the accepting edge, A/B are replaced by a2/b2 when change=1.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_p, input bit change,
                          input logic [W-1:0] a2, input logic [W-1:0] b2);
        A     = a;
        B     = b;
        start = 1'b1;
        exp_q.push_back(exp_p);
        for (int idx = 1; idx <= W + 1; idx++) begin
            @(negedge clk);
            if (idx == 1) begin
                start = 1'b0;
                if (change) begin
                    A = a2;
                    B = b2;
                end
            end
            check("busy", 32'(busy), 32'(idx <= W));
            check("done", 32'(done), 32'(idx == W + 1));
            if (idx <= W) check("p_hold_run", 32'(P), 32'(last_p));
            if (done) score_done();
        end
        last_p = exp_p;
        @(negedge clk);
        check("done_pulse_end", 32'(done), 32'(0));
        check("idle_after", 32'(busy), 32'(0));
        check("p_hold_idle", 32'(P), 32'(exp_p));
    endtask

    initial begin
        int n_done;
        int t_done[3];
        logic [W-1:0] ra, rb;

        vecs[0]  = '{a: 8'd13,  b: 8'd11,  p: 16'h008F};
        vecs[1]  = '{a: 8'd255, b: 8'd255, p: 16'hFE01};
        vecs[2]  = '{a: 8'd0,   b: 8'd200, p: 16'h0000};
        vecs[3]  = '{a: 8'd200, b: 8'd0,   p: 16'h0000};
        vecs[4]  = '{a: 8'd1,   b: 8'd1,   p: 16'h0001};
        vecs[5]  = '{a: 8'd3,   b: 8'd5,   p: 16'h000F};
        vecs[6]  = '{a: 8'd7,   b: 8'd9,   p: 16'h003F};
        vecs[7]  = '{a: 8'd128, b: 8'd2,   p: 16'h0100};
        vecs[8]  = '{a: 8'd255, b: 8'd1,   p: 16'h00FF};
        vecs[9]  = '{a: 8'd16,  b: 8'd16,  p: 16'h0100};
        vecs[10] = '{a: 8'd170, b: 8'd85,  p: 16'd14450};

        // reset, with start high to show it is not taken while rst=1
        rst    = 1'b1;
        start  = 1'b1;
        A      = 8'd9;
        B      = 8'd9;
        last_p = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_p", 32'(P), 32'(0));
        check("reset_state", 32'(state_o), 32'(IDLE));

        // first start accepted at the first edge with rst=0
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0, '0, '0);
        end

        // operands overwritten during RUN must not matter
        run_op(8'd7, 8'd9, 16'h003F, 1'b1, 8'hFF, 8'hFF);

        // start held high: back-to-back products, done every W+2 cycles
        A      = 8'd3;
        B      = 8'd5;
        start  = 1'b1;
        n_done = 0;
        repeat (3) exp_q.push_back(16'd15);
        for (int idx = 1; idx <= 3 * (W + 2); idx++) begin
            @(negedge clk);
            if (done) begin
                if (n_done < 3) t_done[n_done] = idx;
                n_done++;
                score_done();
            end
            if (idx == 3 * (W + 2)) start = 1'b0;
        end
        check("held_done_count", 32'(n_done), 32'(3));
        check("held_first_latency", 32'(t_done[0]), 32'(W + 1));
        check("held_spacing_1", 32'(t_done[1] - t_done[0]), 32'(W + 2));
        check("held_spacing_2", 32'(t_done[2] - t_done[1]), 32'(W + 2));
        @(negedge clk);
        check("held_idle", 32'(busy), 32'(0));
        last_p = 16'd15;

        // reset on the 4th RUN cycle aborts with no done pulse
        A     = 8'd5;
        B     = 8'd6;
        start = 1'b1;
        for (int idx = 1; idx <= 4; idx++) begin
            @(negedge clk);
            start = 1'b0;
            check("abort_busy", 32'(busy), 32'(1));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy_clr", 32'(busy), 32'(0));
        check("abort_done_clr", 32'(done), 32'(0));
        check("abort_p_clr", 32'(P), 32'(0));
        check("abort_state", 32'(state_o), 32'(IDLE));
        last_p = '0;
        n_done = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'(0));
        check("abort_p_stays", 32'(P), 32'(0));
        run_op(8'd2, 8'd2, 16'd4, 1'b0, '0, '0);

        // random regression against A*B, operands disturbed during RUN
        for (int n = 0; n < 2000; n++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            run_op(ra, rb, 16'(ra) * 16'(rb), 1'b1,
                   W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        end

        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
